// File: rtl/mmio_uart_tx_if.sv
// MMIO device-bus bundle: active-low read/write strobes, word addresses,
// and the per-device read data/valid return path.
interface mmio_uart_tx_if;
  logic        IN_re;
  logic [29:0] IN_raddr;
  logic [31:0] OUT_rdata;
  logic        OUT_rbusy;
  logic        OUT_rvalid;
  logic        IN_we;
  logic [3:0]  IN_wmask;
  logic [29:0] IN_waddr;
  logic [31:0] IN_wdata;

  modport master (
    output IN_re, IN_raddr, IN_we, IN_wmask, IN_waddr, IN_wdata,
    input  OUT_rdata, OUT_rbusy, OUT_rvalid
  );

  modport slave (
    input  IN_re, IN_raddr, IN_we, IN_wmask, IN_waddr, IN_wdata,
    output OUT_rdata, OUT_rbusy, OUT_rvalid
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Transmit-only 8N1 UART on the MMIO bus: TX FIFO, baud FSM, drain interrupt.
// Reads return one cycle after the request; writes never stall, a push to a full FIFO is dropped.
module mmio_uart_tx #(
  parameter logic [31:0] ADDR       = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] RESET_DIV  = 16'd867
) (
  input  logic            clk,
  input  logic            rst,
  mmio_uart_tx_if.slave   bus,
  output logic            OUT_tx,
  output logic            OUT_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rptr_q, wptr_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic [15:0]   div_q;
  logic          irq_en_q;
  logic [15:0]   baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q, irq_q, rvalid_q;
  logic [31:0]   rdata_q;

  logic        rhit, whit, full, empty, push_req, push, pop, ovf_clr;
  logic [31:0] status, rd_val;
  logic [5:0]  cnt6;
  logic        unused_ok;

  assign rhit = !bus.IN_re && (bus.IN_raddr[29:2] == ADDR[31:4]) && (bus.IN_raddr[1:0] != 2'd3);
  assign whit = !bus.IN_we && (bus.IN_waddr[29:2] == ADDR[31:4]) && (bus.IN_waddr[1:0] != 2'd3);

  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  assign empty    = (cnt_q == '0);
  assign push_req = whit && (bus.IN_waddr[1:0] == 2'd0) && bus.IN_wmask[0];
  assign push     = push_req && !full;
  assign pop      = (state_q == IDLE) && !empty;
  assign ovf_clr  = whit && (bus.IN_waddr[1:0] == 2'd1) && bus.IN_wmask[0] && bus.IN_wdata[3];

  assign cnt6   = 6'(cnt_q);
  assign status = {18'd0, cnt6, 4'd0, ovf_q, (state_q != IDLE), empty, full};

  always_comb begin
    rd_val = '0;
    case (bus.IN_raddr[1:0])
      2'd1:    rd_val = status;
      2'd2:    rd_val = {15'd0, irq_en_q, div_q};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.IN_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rptr_q   <= '0;
      wptr_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      div_q    <= RESET_DIV;
      irq_en_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      // Read data is sampled before this edge's writes land, so a same-cycle
      // read sees the pre-write state.
      rvalid_q <= rhit;
      rdata_q  <= rhit ? rd_val : '0;

      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (!push && pop) cnt_q <= cnt_q - CW'(1);

      if (push_req && full) ovf_q <= 1'b1;
      else if (ovf_clr)     ovf_q <= 1'b0;

      if (whit && bus.IN_waddr[1:0] == 2'd2) begin
        if (bus.IN_wmask[0]) div_q[7:0]  <= bus.IN_wdata[7:0];
        if (bus.IN_wmask[1]) div_q[15:8] <= bus.IN_wdata[15:8];
        if (bus.IN_wmask[2]) irq_en_q    <= bus.IN_wdata[16];
      end

      irq_q <= irq_en_q && empty && (state_q == IDLE);

      // tx_q is loaded with the level of the state being entered, so the
      // line and the state change on the same edge.
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (!empty) begin
            shift_q <= mem_q[rptr_q];
            baud_q  <= div_q;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_q == 16'd0) begin
            baud_q  <= div_q;
            bit_q   <= 3'd0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        DATA: begin
          if (baud_q == 16'd0) begin
            baud_q  <= div_q;
            shift_q <= shift_q >> 1;
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              tx_q <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (baud_q == 16'd0) state_q <= IDLE;
          else                 baud_q  <= baud_q - 16'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign unused_ok = ^{bus.IN_wdata[31:17], bus.IN_wmask[3]};

  assign bus.OUT_rdata  = rdata_q;
  assign bus.OUT_rvalid = rvalid_q;
  assign bus.OUT_rbusy  = 1'b0;
  assign OUT_tx         = tx_q;
  assign OUT_irq        = irq_q;
endmodule
